// File: rtl/seven_seg_pkg.sv
// -----------------------------------------------------------------------------
// seven_seg_pkg
//   Shared types and constants for the 4-digit seven-segment scanner.
//   - bcd_t / seg_t      : one BCD digit, one active-high segment pattern
//                          (bit0 = a ... bit6 = g)
//   - digit_set_t        : a full captured set (four digits + dp enables)
//   - dig_idx_t          : scan slot / digit index, thousands first
//   - anode_onehot()     : active-high anode select for a slot
// -----------------------------------------------------------------------------
package seven_seg_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;

  // Active-high patterns; polarity is applied only at the output register.
  localparam seg_t SEG_BLANK = 7'h00;
  localparam seg_t SEG_DASH  = 7'h40;  // segment g only

  typedef enum logic [1:0] {
    DIG_THOU = 2'd0,
    DIG_HUND = 2'd1,
    DIG_TENS = 2'd2,
    DIG_ONES = 2'd3
  } dig_idx_t;

  // dp bit order matches the anode order: bit3 = thousands, bit0 = ones.
  typedef struct packed {
    bcd_t       thou;
    bcd_t       hund;
    bcd_t       tens;
    bcd_t       ones;
    logic [3:0] dp;
  } digit_set_t;

  // Slot order walks thousands -> ones, and wraps naturally at 2 bits.
  function automatic dig_idx_t next_slot(input dig_idx_t s);
    return dig_idx_t'(s + 2'd1);
  endfunction

  // Slot 0 (thousands) drives anode bit 3, slot 3 (ones) drives bit 0.
  function automatic logic [3:0] anode_onehot(input dig_idx_t s);
    logic [3:0] sel;
    sel = 4'b1000;
    return sel >> s;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// -----------------------------------------------------------------------------
// bcd_to_seg7
//   Combinational BCD to seven-segment decoder, active-high outputs.
//   Codes 0-9 give the standard digit shapes; 10-15 give a dash so that an
//   out-of-range upstream value is visibly wrong rather than silently blank.
//   Ports:
//     bcd  in  4  digit code
//     seg  out 7  segment pattern, bit0 = a ... bit6 = g
// -----------------------------------------------------------------------------
module bcd_to_seg7
  import seven_seg_pkg::*;
(
  input  bcd_t bcd,
  output seg_t seg
);

  always_comb begin
    seg = SEG_DASH;
    unique case (bcd)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// -----------------------------------------------------------------------------
// seven_seg_scanner
//   Time-multiplexes four BCD digits onto a 4-digit common-anode display.
//   A valid/ready handshake captures new digit sets into a one-entry pending
//   buffer; the displayed (active) set only changes on a frame boundary, so a
//   scan frame never mixes two digit sets. Each slot starts with a short guard
//   interval with every anode off to suppress ghosting between digits.
//
//   Parameters:
//     SCAN_DIV       clk cycles per digit slot (4..65535)
//     GUARD          anodes-off cycles at the start of each slot (< SCAN_DIV)
//     BLANK_LEADING  1 = blank leading zeros
//     SEG_ACTIVE_LOW 1 = segments, dp and anodes light when driven low
//
//   Ports:
//     clk           in   system clock
//     reset_n       in   asynchronous active-low reset
//     thousands..ones in 4 BCD digits, thousands is the MSB
//     dp_in         in   4 decimal-point enables (bit3 = thousands)
//     digits_valid  in   upstream offers a digit set
//     digits_ready  out  a digit set can be accepted this cycle
//     segments      out  7 segment drive, bit0 = a ... bit6 = g
//     dp            out  decimal-point drive
//     anode         out  4 digit select (bit3 = thousands)
//     frame_start   out  one-cycle pulse as slot 0 of a frame begins
// -----------------------------------------------------------------------------
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int GUARD          = 4,
  parameter int BLANK_LEADING  = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] thousands,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic [3:0] dp_in,
  input  logic       digits_valid,
  output logic       digits_ready,
  output logic [6:0] segments,
  output logic       dp,
  output logic [3:0] anode,
  output logic       frame_start
);

  localparam int               DIV_W     = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_TC    = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] GUARD_CNT = DIV_W'(GUARD);
  localparam logic             POL       = (SEG_ACTIVE_LOW != 0);
  localparam logic             BLANK_EN  = (BLANK_LEADING != 0);

  // ---------------------------------------------------------------------------
  // Divider and slot counter
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt;
  dig_idx_t         slot;
  logic             at_tc;
  logic             frame_edge;

  assign at_tc      = (div_cnt == DIV_TC);
  assign frame_edge = at_tc && (slot == DIG_ONES);

  // NOTE: state registers use non-blocking assignments so every always_ff
  // sees the pre-edge value of every other register, whatever the order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      slot    <= DIG_THOU;
    end else if (at_tc) begin
      div_cnt <= '0;
      slot    <= next_slot(slot);
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Capture handshake with a one-entry pending buffer
  // ---------------------------------------------------------------------------
  digit_set_t incoming;
  digit_set_t pending;
  digit_set_t active;
  logic       pending_full;
  logic       accept;

  assign incoming = '{thou: thousands, hund: hundreds, tens: tens,
                      ones: ones, dp: dp_in};

  // Ready comes straight from a register, so it is glitch-free and has no
  // combinational path back from digits_valid.
  assign digits_ready = !pending_full;
  assign accept       = digits_valid && digits_ready;

  // NOTE: the digit buffers are reset along with the control bits; the
  // display must come up as a known "0" and a reset must discard any
  // half-delivered set, so these are not left as unreset storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending      <= '0;
      active       <= '0;
      pending_full <= 1'b0;
    end else if (frame_edge) begin
      if (pending_full) begin
        // ready is low while full, so no accept can collide with this copy
        active       <= pending;
        pending_full <= 1'b0;
      end else if (accept) begin
        // Bypass: the set arrives exactly on the boundary, show it next frame
        active <= incoming;
      end
    end else if (accept) begin
      pending      <= incoming;
      pending_full <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Digit select, leading-zero blanking and decode
  // ---------------------------------------------------------------------------
  logic lz_thou;
  logic lz_hund;
  logic lz_tens;
  bcd_t sel_bcd;
  logic sel_blank;
  logic sel_dp;
  seg_t dec_seg;
  seg_t seg_next;
  logic [3:0] anode_next;

  // A dash code is nonzero, so it stops the blanking run like any digit.
  assign lz_thou = (active.thou == 4'd0);
  assign lz_hund = lz_thou && (active.hund == 4'd0);
  assign lz_tens = lz_hund && (active.tens == 4'd0);

  // NOTE: every output of this block is given a default before the case so
  // no path leaves a value unassigned, which would infer a latch.
  always_comb begin
    sel_bcd   = active.ones;
    sel_blank = 1'b0;
    sel_dp    = active.dp[0];
    unique case (slot)
      DIG_THOU: begin
        sel_bcd   = active.thou;
        sel_blank = lz_thou;
        sel_dp    = active.dp[3];
      end
      DIG_HUND: begin
        sel_bcd   = active.hund;
        sel_blank = lz_hund;
        sel_dp    = active.dp[2];
      end
      DIG_TENS: begin
        sel_bcd   = active.tens;
        sel_blank = lz_tens;
        sel_dp    = active.dp[1];
      end
      DIG_ONES: begin
        sel_bcd   = active.ones;
        sel_blank = 1'b0;
        sel_dp    = active.dp[0];
      end
      default: ;
    endcase
  end

  bcd_to_seg7 u_dec (
    .bcd (sel_bcd),
    .seg (dec_seg)
  );

  // Blanking hides segments only; the decimal point still follows dp_in.
  assign seg_next   = (BLANK_EN && sel_blank) ? SEG_BLANK : dec_seg;
  assign anode_next = (div_cnt < GUARD_CNT) ? 4'b0000 : anode_onehot(slot);

  // ---------------------------------------------------------------------------
  // Output register; polarity applied here and nowhere else
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      anode       <= {4{POL}};
      segments    <= {7{POL}};
      dp          <= POL;
      frame_start <= 1'b0;
    end else begin
      anode       <= anode_next ^ {4{POL}};
      segments    <= seg_next ^ {7{POL}};
      dp          <= sel_dp ^ POL;
      frame_start <= frame_edge;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_scanner
//   Two scanners (leading-zero blanking on and off) share one stimulus.
//   A frame-level reference model derives slot, guard and frame position from
//   the number of clock edges since reset, and tracks which digit set is on
//   display from the handshake rules. Table vectors and hand sequences add
//   fixed expected segment codes for the interesting digit patterns.
// -----------------------------------------------------------------------------
module tb_seven_seg_scanner;

  localparam int SD = 8;
  localparam int GD = 2;
  localparam int FR = 4 * SD;

  localparam logic [6:0] PAT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] th = '0, hu = '0, te = '0, on = '0, dpv = '0;
  logic       valid = 1'b0;

  logic       rdy, dp, fs;
  logic [6:0] seg;
  logic [3:0] an;
  logic       rdy_nb, dp_nb, fs_nb;
  logic [6:0] seg_nb;
  logic [3:0] an_nb;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int         m_n;
  logic [3:0] m_act [4];
  logic [3:0] m_pend [4];
  logic [3:0] m_act_dp, m_pend_dp;
  bit         m_pend_full;

  always #5 clk = ~clk;

  seven_seg_scanner #(.SCAN_DIV(SD), .GUARD(GD), .BLANK_LEADING(1),
                      .SEG_ACTIVE_LOW(1)) dut (
    .clk(clk), .reset_n(reset_n), .thousands(th), .hundreds(hu), .tens(te),
    .ones(on), .dp_in(dpv), .digits_valid(valid), .digits_ready(rdy),
    .segments(seg), .dp(dp), .anode(an), .frame_start(fs));

  seven_seg_scanner #(.SCAN_DIV(SD), .GUARD(GD), .BLANK_LEADING(0),
                      .SEG_ACTIVE_LOW(1)) dut_nb (
    .clk(clk), .reset_n(reset_n), .thousands(th), .hundreds(hu), .tens(te),
    .ones(on), .dp_in(dpv), .digits_valid(valid), .digits_ready(rdy_nb),
    .segments(seg_nb), .dp(dp_nb), .anode(an_nb), .frame_start(fs_nb));

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, got, want);
    end
  endtask

  task automatic model_reset();
    m_n = 0;
    for (int i = 0; i < 4; i++) begin
      m_act[i]  = '0;
      m_pend[i] = '0;
    end
    m_act_dp    = '0;
    m_pend_dp   = '0;
    m_pend_full = 1'b0;
  endtask

  // Active-low expected segments for slot s (0 = thousands) of the shown set.
  function automatic logic [6:0] exp_seg(input int s, input bit blank_en);
    bit lead;
    lead = 1'b1;
    for (int i = 0; i <= s; i++)
      if (m_act[i] != 4'd0) lead = 1'b0;
    if (blank_en && s < 3 && lead) return 7'h7F;
    if (m_act[s] <= 4'd9) return ~PAT[m_act[s]];
    return 7'h3F;
  endfunction

  // One clock edge: predict, advance, compare 1 time unit later, update model.
  task automatic tick();
    int         div, slot;
    logic [3:0] e_an;
    logic [6:0] e_s, e_snb;
    logic       e_dp;
    bit         bnd, acc;
    logic [3:0] c_d [4];
    logic [3:0] c_dp;
    div   = m_n % SD;
    slot  = (m_n / SD) % 4;
    e_an  = (div < GD) ? 4'hF : ~(4'b1000 >> slot);
    e_s   = exp_seg(slot, 1'b1);
    e_snb = exp_seg(slot, 1'b0);
    e_dp  = ~m_act_dp[3 - slot];
    bnd   = (div == SD - 1) && (slot == 3);
    acc   = valid && !m_pend_full;
    c_d   = '{th, hu, te, on};
    c_dp  = dpv;
    @(posedge clk);
    #1;
    check("anode", an, e_an);
    check("anode_nb", an_nb, e_an);
    check("frame_start", fs, bnd);
    check("frame_start_nb", fs_nb, bnd);
    if (e_an != 4'hF) begin
      check("segments", seg, e_s);
      check("segments_nb", seg_nb, e_snb);
      check("dp", dp, e_dp);
      check("dp_nb", dp_nb, e_dp);
    end
    if (bnd) begin
      if (m_pend_full) begin
        m_act       = m_pend;
        m_act_dp    = m_pend_dp;
        m_pend_full = 1'b0;
      end else if (acc) begin
        m_act    = c_d;
        m_act_dp = c_dp;
      end
    end else if (acc) begin
      m_pend      = c_d;
      m_pend_dp   = c_dp;
      m_pend_full = 1'b1;
    end
    check("ready", rdy, !m_pend_full);
    check("ready_nb", rdy_nb, !m_pend_full);
    m_n++;
  endtask

  task automatic tick_until_phase(input int ph);
    for (int i = 0; i < 2 * FR; i++) begin
      if (m_n % FR == ph) return;
      tick();
    end
    check("phase_reached", m_n % FR, ph);
  endtask

  task automatic rand_inputs();
    th  = 4'($urandom_range(0, 15));
    hu  = 4'($urandom_range(0, 15));
    te  = 4'($urandom_range(0, 15));
    on  = 4'($urandom_range(0, 15));
    dpv = 4'($urandom_range(0, 15));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_anode"}, an, 4'hF);
    check({tag, "_segments"}, seg, 7'h7F);
    check({tag, "_dp"}, dp, 1'b1);
    check({tag, "_ready"}, rdy, 1'b1);
    check({tag, "_frame_start"}, fs, 1'b0);
    check({tag, "_anode_nb"}, an_nb, 4'hF);
    check({tag, "_segments_nb"}, seg_nb, 7'h7F);
    check({tag, "_ready_nb"}, rdy_nb, 1'b1);
  endtask

  // Table vectors: digits {thou,hund,tens,ones}, dp_in, expected active-low
  // segments per slot {thou,hund,tens,ones} with and without blanking, and
  // expected dp per slot (bit3 = thousands slot).
  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  dpi;
    logic [27:0] s_bl;
    logic [27:0] s_nb;
    logic [3:0]  dpo;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, period, lit, acc_cnt, s;
    bit took;

    tbl[0] = '{16'h1234, 4'b0000, {7'h79, 7'h24, 7'h30, 7'h19},
               {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111};
    tbl[1] = '{16'h0040, 4'b0000, {7'h7F, 7'h7F, 7'h19, 7'h40},
               {7'h40, 7'h40, 7'h19, 7'h40}, 4'b1111};
    tbl[2] = '{16'h00C5, 4'b0010, {7'h7F, 7'h7F, 7'h3F, 7'h12},
               {7'h40, 7'h40, 7'h3F, 7'h12}, 4'b1101};
    tbl[3] = '{16'h0000, 4'b1000, {7'h7F, 7'h7F, 7'h7F, 7'h40},
               {7'h40, 7'h40, 7'h40, 7'h40}, 4'b0111};
    tbl[4] = '{16'h9007, 4'b0000, {7'h10, 7'h40, 7'h40, 7'h78},
               {7'h10, 7'h40, 7'h40, 7'h78}, 4'b1111};
    tbl[5] = '{16'h0F08, 4'b0101, {7'h7F, 7'h3F, 7'h40, 7'h00},
               {7'h40, 7'h3F, 7'h40, 7'h00}, 4'b1010};

    // Reset state
    model_reset();
    #12;
    check_idle_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Free run: frame_start period and lit cycles of the thousands slot
    first  = -1;
    period = 0;
    lit    = 0;
    for (int k = 0; k < 80; k++) begin
      tick();
      if (fs) begin
        if (first < 0) first = k;
        else if (period == 0) period = k - first;
      end
      if (k >= 32 && k < 64 && an == 4'b0111) lit++;
    end
    check("frame_start_period", period, FR);
    check("thou_lit_cycles", lit, SD - GD);

    // Table vectors, each loaded with a one-cycle valid mid-frame
    for (int i = 0; i < 6; i++) begin
      tick_until_phase(12);
      th  = tbl[i].d[15:12];
      hu  = tbl[i].d[11:8];
      te  = tbl[i].d[7:4];
      on  = tbl[i].d[3:0];
      dpv = tbl[i].dpi;
      valid = 1'b1;
      tick();
      valid = 1'b0;
      check("tbl_ready_low", rdy, 1'b0);
      tick_until_phase(0);
      for (int k = 1; k <= FR; k++) begin
        tick();
        if (k % SD == 0) begin
          s = k / SD - 1;
          check($sformatf("tbl%0d_seg_slot%0d", i, s), seg,
                tbl[i].s_bl[(3 - s) * 7 +: 7]);
          check($sformatf("tbl%0d_segnb_slot%0d", i, s), seg_nb,
                tbl[i].s_nb[(3 - s) * 7 +: 7]);
          check($sformatf("tbl%0d_dp_slot%0d", i, s), dp, tbl[i].dpo[3 - s]);
        end
      end
    end

    // Valid held high, new value after each accept: one accept per frame
    tick_until_phase(10);
    rand_inputs();
    valid   = 1'b1;
    acc_cnt = 0;
    for (int k = 0; k < 4 * FR; k++) begin
      took = valid && rdy;
      tick();
      if (took) begin
        acc_cnt++;
        rand_inputs();
      end
    end
    valid = 1'b0;
    check("accepts_in_4_frames", acc_cnt, 5);

    // Accept on the frame-boundary edge with pending empty: bypass
    tick_until_phase(0);
    tick_until_phase(FR - 1);
    check("bypass_pending_empty", rdy, 1'b1);
    th = 4'd5; hu = 4'd6; te = 4'd7; on = 4'd8; dpv = 4'b0001;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    check("bypass_ready_high", rdy, 1'b1);
    for (int k = 1; k <= FR; k++) begin
      tick();
      if (k == SD) check("bypass_thou_seg", seg, 7'h12);
      if (k == FR) begin
        check("bypass_ones_seg", seg, 7'h00);
        check("bypass_ones_dp", dp, 1'b0);
      end
    end

    // Random traffic; data held stable while valid && !ready
    for (int k = 0; k < 1500; k++) begin
      if (!(valid && m_pend_full)) begin
        valid = ($urandom_range(0, 3) == 0);
        rand_inputs();
      end
      tick();
    end
    valid = 1'b0;

    // Reset mid-slot with a set pending: immediate idle outputs, data dropped
    tick_until_phase(12);
    th = 4'd9; hu = 4'd9; te = 4'd9; on = 4'd9; dpv = 4'hF;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    check("pre_reset_ready_low", rdy, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    for (int k = 0; k < 2 * FR; k++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Consumes the four BCD digits (thousands, hundreds, tens, ones) produced by the digit separator stage.
- Time-multiplexes them onto a 4-digit common-anode 7-segment display on the MachXO2 board.
- Provides a valid/ready capture handshake with a pending buffer. New values take effect only at a scan-frame boundary, so no frame ever mixes old and new digits.
- Provides leading-zero blanking and an anti-ghosting guard interval.

Parameters:
- SCAN_DIV, 1000: clk cycles per digit slot; legal range 4..65535.
- GUARD, 4: cycles at the start of each slot with all anodes off; must be less than SCAN_DIV.
- BLANK_LEADING, 1: 1 enables leading-zero blanking; 0 shows all digits.
- SEG_ACTIVE_LOW, 1: 1 means segments, dp and anodes are driven low to light.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- thousands  in  4  BCD MSB digit
- hundreds  in  4  BCD digit
- tens  in  4  BCD digit
- ones  in  4  BCD LSB digit
- dp_in  in  4  decimal-point enables; bit3 = thousands, bit0 = ones
- digits_valid  in  1  upstream offers a new digit set
- digits_ready  out  1  block can accept a set
- segments  out  7  segment drive; bit0 = a ... bit6 = g
- dp  out  1  decimal-point drive
- anode  out  4  digit select; bit3 = thousands, bit0 = ones
- frame_start  out  1  one-cycle pulse when slot 0 of a frame begins

Behaviour:
- One clock domain: clk. reset_n is asynchronous, active-low.
- All outputs are registered.
- Reset values:
  - div_cnt=0, slot=0.
  - Active digits = 0, active dp = 0.
  - Pending buffer empty, digits_ready=1.
  - anode, segments and dp all at the inactive level (all 1s when SEG_ACTIVE_LOW=1).
  - frame_start=0.
- Reset mid-operation: immediate return to reset values; any pending or partial data is discarded.
- Divider:
  - div_cnt counts 0..SCAN_DIV-1.
  - At the terminal count (TC) it wraps to 0 and slot advances: 0 (thousands) -> 1 -> 2 -> 3 (ones) -> 0.
  - Frame boundary = TC while slot==3.
- Handshake:
  - Accept when digits_valid && digits_ready; digits and dp_in are sampled on that edge.
  - digits_ready = !pending_full.
  - Upstream may hold digits_valid high; data must be stable while valid && !ready.
- Pending buffer:
  - An accept not on a frame-boundary edge loads pending; pending_full=1 and ready falls on the next cycle.
  - On a frame-boundary edge with pending full, pending copies to active and pending_full clears; ready=1 the next cycle.
  - An accept on a frame-boundary edge with pending empty writes active directly (bypass); pending stays empty.
  - Active registers change only on frame-boundary edges.
- Output timing:
  - Each output reflects slot/div_cnt state with one cycle of register latency.
  - During div_cnt < GUARD, anode is all inactive.
  - Otherwise exactly one anode bit is active, selected by slot.
- frame_start:
  - Registered pulse, high for exactly one cycle on the cycle after the frame-boundary edge.
  - That is the first cycle of slot 0 of the new frame, aligned with the guard interval.
- Decode:
  - Codes 0-9 use standard 7-segment patterns.
  - Codes 10-15 render a dash (g only).
- Leading-zero blanking (BLANK_LEADING=1):
  - Thousands is blanked if 0.
  - Hundreds is blanked if thousands==0 and hundreds==0.
  - Tens is blanked if thousands, hundreds and tens are all 0.
  - Ones is never blanked.
  - A dash code counts as nonzero.
  - A blanked digit shows no segments, but its dp is still driven from dp_in.
- Polarity: SEG_ACTIVE_LOW inverts segments, dp and anode at the output register only.

Decomposition:
- Package seven_seg_pkg:
  - typedef bcd_t (logic [3:0]).
  - typedef seg_t (logic [6:0]).
  - Constants SEG_BLANK and SEG_DASH.
  - Localparam digit-index enum: DIG_THOU=0, DIG_HUND=1, DIG_TENS=2, DIG_ONES=3.
- Sub-module bcd_to_seg7: combinational bcd_t -> seg_t, active-high. It is instantiated once on the selected digit, ahead of the output register.
- Divider, slot counter, handshake/pending buffer and blanking logic live in the top module.

Test Plan (SCAN_DIV=8, GUARD=2, SEG_ACTIVE_LOW=1):
- Reset then free-run:
  - anode walks 0111, 1011, 1101, 1110.
  - Each digit is low for 6 cycles after 2 guard cycles of 1111.
  - frame_start pulses every 32 cycles.
- Load 1,2,3,4 with valid one cycle mid-frame:
  - ready low until the next boundary.
  - Segments show 0x79, 0x24, 0x30, 0x19 from the next frame on.
  - The current frame still shows the old digits.
- Load 0,0,4,0:
  - thousands and hundreds slots show 0x7F.
  - tens shows 0x19, ones shows 0x40.
  - With BLANK_LEADING=0, all slots light and zero shows 0x40.
- Hold valid continuously with a new value each accept:
  - Exactly one accept per frame.
  - No frame ever shows mixed digit sets.
- Accept coincident with a frame-boundary edge while pending is empty:
  - The new digits show in the immediately following slot 0.
  - ready never drops.
- Digit code 12 with dp_in=4'b0010:
  - That slot shows 0x3F (dash).
  - dp is low only in the tens slot.
- Assert reset_n low mid-slot: anode, segments and dp are all 1s asynchronously, and ready=1.
